// File: rtl/value_wait_if.sv
// value_wait_if: command/response/monitor bundle for value_wait_engine.
interface value_wait_if #(parameter int WIDTH = 32, parameter int CNT_W = 16);
  logic signed [WIDTH-1:0] value;
  logic cmd_valid;
  logic cmd_ready;
  logic [2:0] cmd_op;
  logic signed [WIDTH-1:0] cmd_a;
  logic signed [WIDTH-1:0] cmd_b;
  logic [CNT_W-1:0] cmd_timeout;
  logic resp_valid;
  logic resp_ready;
  logic resp_timeout;
  logic [CNT_W-1:0] resp_cycles;
  logic busy;
  modport master(output value, cmd_valid, cmd_op, cmd_a, cmd_b, cmd_timeout, resp_ready,
                 input cmd_ready, resp_valid, resp_timeout, resp_cycles, busy);
  modport slave(input value, cmd_valid, cmd_op, cmd_a, cmd_b, cmd_timeout, resp_ready,
                output cmd_ready, resp_valid, resp_timeout, resp_cycles, busy);
endinterface

// File: rtl/value_wait_engine.sv
// value_wait_engine: waits for a signed predicate on value, or a cycle timeout, then responds.
module value_wait_engine #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  value_wait_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0] state_q, state_d;
  logic [2:0] op_q, op_d;
  logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d, v;
  logic [CNT_W-1:0] to_q, to_d, cnt_q, cnt_d, cyc_q, cyc_d;
  logic tmo_q, tmo_d, hit, last;
  assign v = bus.value;
  assign hit = op_q == 3'd0 ? v == a_q :
               op_q == 3'd1 ? v != a_q :
               op_q == 3'd2 ? v < a_q :
               op_q == 3'd3 ? v >= a_q : (v > a_q && v < b_q);
  assign last = to_q != '0 && cnt_q == to_q - 1'b1;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    to_d = to_q;
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    cyc_d = cyc_q;
    if (state_q == IDLE) begin
      if (bus.cmd_valid) begin
        op_d = bus.cmd_op;
        a_d = bus.cmd_a;
        b_d = bus.cmd_b;
        to_d = bus.cmd_timeout;
        cnt_d = '0;
        state_d = bus.cmd_op > 3'd4 ? RESP : WAIT;
        tmo_d = bus.cmd_op > 3'd4;
        cyc_d = bus.cmd_op > 3'd4 ? '0 : cyc_q;
      end
    end else if (state_q == WAIT) begin
      // a true predicate takes priority over a coincident timeout
      state_d = hit || last ? RESP : WAIT;
      tmo_d = hit ? 1'b0 : last ? 1'b1 : tmo_q;
      cyc_d = hit ? cnt_q : last ? to_q : cyc_q;
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, ~&cnt_q};
    end else if (state_q == RESP) begin
      state_d = bus.resp_ready ? IDLE : RESP;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      to_q <= '0;
      cnt_q <= '0;
      tmo_q <= 1'b0;
      cyc_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      to_q <= to_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      cyc_q <= cyc_d;
    end
  end
  assign bus.cmd_ready = state_q == IDLE;
  assign bus.resp_valid = state_q == RESP;
  assign bus.busy = state_q != IDLE;
  assign bus.resp_timeout = tmo_q;
  assign bus.resp_cycles = cyc_q;
endmodule

// File: tb/tb_value_wait_engine.sv
// tb_value_wait_engine: directed + random commands checked against a sequence-level model.
module tb_value_wait_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  int gc = 0;
  value_wait_if #(.WIDTH(32), .CNT_W(16)) bus ();
  value_wait_engine #(.WIDTH(32), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) gc <= gc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic bit pred(input int op, input int a, input int b, input int v);
    case (op)
      0: return v == a;
      1: return v != a;
      2: return v < a;
      3: return v >= a;
      default: return v > a && v < b;
    endcase
  endfunction

  // eval k sees vals[k]; the last entry is held forever
  function automatic void model(input int op, input int a, input int b, input int to, input int vals[$],
                                output int tmo, output int cyc, output int lat, output bit inf);
    inf = 1'b0;
    if (op > 4) begin
      tmo = 1; cyc = 0; lat = 0;
      return;
    end
    for (int k = 0; k < 300; k++) begin
      if (pred(op, a, b, vals[k < vals.size() ? k : vals.size() - 1])) begin
        tmo = 0; cyc = k; lat = k + 1;
        return;
      end
      if (to != 0 && k + 1 == to) begin
        tmo = 1; cyc = to; lat = to;
        return;
      end
    end
    tmo = 0; cyc = 0; lat = 0; inf = 1'b1;
  endfunction

  // call just after a rising edge
  task automatic run_cmd(input int op, input int a, input int b, input int to, input int vals[$], input int hold);
    int tmo, cyc, lat, c, sc;
    bit inf;
    model(op, a, b, to, vals, tmo, cyc, lat, inf);
    @(negedge clk);
    chk("cmd_ready_idle", int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'(op);
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_timeout = 16'(to);
    bus.value = vals[0];
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 3'd1;
    bus.cmd_a = $urandom;
    bus.cmd_b = $urandom;
    bus.cmd_timeout = 16'd1;
    c = 0;
    while (!bus.resp_valid && c < 400) begin
      bus.value = vals[c < vals.size() ? c : vals.size() - 1];
      @(posedge clk);
      #1;
      c++;
    end
    chk("latency", c, lat);
    chk("resp_timeout", int'(bus.resp_timeout), tmo);
    chk("resp_cycles", int'(bus.resp_cycles), cyc);
    chk("busy_resp", int'(bus.busy), 1);
    sc = int'(bus.resp_cycles);
    for (int h = 0; h < hold; h++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op = 3'd0;
      bus.cmd_a = bus.value;
      @(posedge clk);
      #1;
      chk("hold_valid", int'(bus.resp_valid), 1);
      chk("hold_cycles", int'(bus.resp_cycles), sc);
      chk("hold_cmd_ready", int'(bus.cmd_ready), 0);
    end
    bus.cmd_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    chk("released_valid", int'(bus.resp_valid), 0);
    chk("released_ready", int'(bus.cmd_ready), 1);
    chk("released_busy", int'(bus.busy), 0);
  endtask

  function automatic int stepv(input int t);
    return t < 10 ? 0 : t < 20 ? 1 : t < 30 ? 2 : t < 40 ? 0 : 2;
  endfunction

  task automatic step_cmd(input int op, input int a, input int b, input int base);
    int vals[$];
    int e;
    e = gc + 1;
    for (int k = 0; k < 80; k++) vals.push_back(stepv(e + 1 + k - base));
    run_cmd(op, a, b, 0, vals, 0);
  endtask

  initial begin
    int base, op, a, b, to, tmo, cyc, lat;
    int vals[$];
    bit inf;
    bus.value = 0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_a = 0;
    bus.cmd_b = 0;
    bus.cmd_timeout = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("rst_resp_valid", int'(bus.resp_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_resp_timeout", int'(bus.resp_timeout), 0);
    chk("rst_resp_cycles", int'(bus.resp_cycles), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = gc + 1;
    step_cmd(0, 2, 0, base);
    step_cmd(2, 2, 0, base);
    step_cmd(0, 0, 0, base);
    step_cmd(4, 1, 3, base);
    run_cmd(0, 5, 0, 8, '{5}, 0);
    run_cmd(3, 3, 0, 4, '{0}, 0);
    run_cmd(3, 3, 0, 4, '{0, 0, 0, 3}, 0);
    run_cmd(2, 0, 0, 3, '{-1}, 0);
    run_cmd(4, 1, 3, 0, '{1, 3, 2}, 0);
    run_cmd(4, 3, 1, 2, '{2}, 0);
    run_cmd(1, 7, 0, 0, '{7, 7, 8}, 5);
    run_cmd(6, 0, 0, 9, '{0}, 0);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'd3;
    bus.cmd_a = 100;
    bus.cmd_timeout = 16'd0;
    bus.value = 0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("busy_before_rst", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("midrst_resp_valid", int'(bus.resp_valid), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_resp_timeout", int'(bus.resp_timeout), 0);
    chk("midrst_resp_cycles", int'(bus.resp_cycles), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_cmd(0, 1, 0, 6, '{0, 0, 1}, 0);
    for (int i = 0; i < 60; i++) begin
      vals.delete();
      for (int k = 0; k < 12; k++) vals.push_back(int'($urandom_range(0, 8)) - 4);
      op = int'($urandom_range(0, 6));
      a = int'($urandom_range(0, 8)) - 4;
      b = int'($urandom_range(0, 8)) - 4;
      to = int'($urandom_range(0, 10));
      model(op, a, b, to, vals, tmo, cyc, lat, inf);
      if (inf) to = 5;
      run_cmd(op, a, b, to, vals, int'($urandom_range(0, 2)));
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/value_wait_engine.md
# value_wait_engine

Synthesizable wait-until-condition engine: accepts one predicate command at a time, watches a signed `value` bus every clock, and returns a response when the predicate first holds or a programmed cycle timeout expires. Sits directly downstream of the value-producing stage, which drives `value` with a sequence such as 0, 1, 2, 0, 2. It gives RTL the same "wait(expr)" behaviour that the scheduler tests exercise behaviourally. Responses carry the elapsed cycle count so the bench can check scheduling latency.

## Interface

- `WIDTH`, 32: width of `value` and both operands; all compares are signed two's complement.
- `CNT_W`, 16: width of the timeout and elapsed-cycle counters.

- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `value`  in  WIDTH  monitored signed value, sampled every rising edge.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  engine can accept a command.
- `cmd_op`  in  3  0 EQ (v==a), 1 NE (v!=a), 2 LT (v<a), 3 GE (v>=a), 4 RANGE (a<v<b, both bounds exclusive), 5-7 reserved.
- `cmd_a`, `cmd_b`  in  WIDTH  signed operands; `cmd_b` is used only by RANGE.
- `cmd_timeout`  in  CNT_W  maximum evaluations; 0 means no timeout.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  consumer takes the response.
- `resp_timeout`  out  1  1 means the predicate never held (timeout or reserved op).
- `resp_cycles`  out  CNT_W  index of the first true evaluation, or `cmd_timeout` on timeout.
- `busy`  out  1  high in WAIT or RESP.

## Operation

- FSM states: IDLE, WAIT, RESP. Reset returns to IDLE asynchronously, including mid-WAIT or mid-RESP.
- Reset values: `cmd_ready`=1, `resp_valid`=0, `resp_timeout`=0, `resp_cycles`=0, `busy`=0. The latched command and the counter are cleared.
- IDLE: `cmd_ready`=1.
  - On `cmd_valid`, latch op, a, b and timeout; clear the counter.
  - Valid op → WAIT. Reserved op → RESP with `resp_timeout`=1 and `resp_cycles`=0.
- WAIT: `cmd_ready`=0. At each edge, evaluate the predicate on the sampled `value` against the latched operands.
  - True → RESP, `resp_timeout`=0, `resp_cycles`=count.
  - Else if timeout≠0 and count+1==timeout → RESP, `resp_timeout`=1, `resp_cycles`=timeout.
  - Else count+1. With timeout=0 the counter saturates at 2^CNT_W−1 and WAIT continues indefinitely.
  - If the predicate is true on the same edge the timeout would fire, the true result wins.
- RESP: `resp_valid`=1; `resp_timeout`/`resp_cycles` stay stable until `resp_valid && resp_ready`, then → IDLE. `cmd_ready` stays 0 in RESP, so there is no same-cycle command.
- Only latched operands are used; changes on `cmd_*` after acceptance are ignored.
- RANGE with a≥b is never true and always times out (or waits forever if timeout=0).

## Timing

- Accept on edge N. Evaluation k (k≥0) occurs at edge N+1+k and uses `value` as it stood just before that edge.
- Predicate already true at acceptance: `resp_valid` rises after edge N+1 with `resp_cycles`=0. Minimum accept-to-response latency is 1 cycle.
- Timeout T: the last evaluation is k=T−1; `resp_valid` rises after edge N+T.
- `resp_valid` to IDLE: 1 cycle after the handshake edge. Next accept is possible on the following edge, giving a minimum 3-cycle command period.
- A `value` change is seen by the evaluation at the first edge after the change, never earlier.

## Test plan

- Step sequence from reset: `value` holds 0 for 10 cycles, then 1, 2, 0, 2 with 10 cycles each. Issue, back to back, EQ 2 → LT 2 → EQ 0 → RANGE(1,3), all with timeout 0. Responses in that order, all `resp_timeout`=0, with `resp_cycles` matching each transition cycle.
- Already true: `value`=5, EQ 5, timeout 8 → `resp_valid` 1 cycle after accept, `resp_cycles`=0, `resp_timeout`=0.
- Timeout: `value`=0, GE 3, timeout 4 → response after edge N+4, `resp_timeout`=1, `resp_cycles`=4. Same command but `value`=3 arriving just before the 4th evaluation → `resp_timeout`=0, `resp_cycles`=3.
- Signed/boundary compares: `value`=−1 with LT 0 → true. RANGE(1,3) at `value`=1 and `value`=3 → false; at 2 → true. RANGE(3,1) with timeout 2 → timeout.
- Backpressure: hold `resp_ready`=0 for 5 cycles → outputs stable, `cmd_ready`=0, a new `cmd_valid` is ignored; release → IDLE next cycle.
- Reserved op 6 → `resp_timeout`=1, `resp_cycles`=0. `rst_n` low mid-WAIT → IDLE immediately with all outputs at reset values; a new command then completes normally.
